// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - digit values in, multiplexed segment/select bus out
interface seg_scan_driver_if;
  logic [31:0] digit_data;
  logic [7:0]  digit_en;
  logic [7:0]  blink_mask;
  logic [6:0]  seg_display;
  logic [7:0]  seg_position;
  logic        frame_done;

  // Game logic side: supplies digits, observes the scan bus.
  modport master (
    output digit_data, digit_en, blink_mask,
    input  seg_display, seg_position, frame_done
  );

  // Display driver side.
  modport slave (
    input  digit_data, digit_en, blink_mask,
    output seg_display, seg_position, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - eight-digit time-multiplexed 7-segment driver with blanking and blink
module seg_scan_driver #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);
  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
    endcase
    return s;
  endfunction

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [6:0]         seg_display_q, seg_display_d;
  logic [7:0]         seg_position_q, seg_position_d;
  logic               frame_done_q, frame_done_d;

  logic               load;
  logic [3:0]         cur_nibble;
  logic               blanked;

  always_comb begin
    load           = (presc_q == PRESC_LAST);
    cur_nibble     = bus.digit_data[{idx_q, 2'b00} +: 4];
    // Enable wins over blink: a disabled digit is dark in either blink phase.
    blanked        = !bus.digit_en[idx_q] || (bus.blink_mask[idx_q] && blink_phase_q);

    presc_d        = load ? '0 : presc_q + 1'b1;
    idx_d          = idx_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    seg_display_d  = seg_display_q;
    seg_position_d = seg_position_q;
    frame_done_d   = 1'b0;

    if (load) begin
      seg_position_d = ~(8'd1 << idx_q);
      seg_display_d  = blanked ? 7'h00 : hex_to_seg(cur_nibble);
      idx_d          = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        // Digit 7 was decoded above with the old phase; the toggle applies from the next frame.
        frame_done_d = 1'b1;
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d   = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q        <= '0;
      idx_q          <= 3'd0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      seg_display_q  <= 7'h00;
      seg_position_q <= 8'hFF;
      frame_done_q   <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      seg_display_q  <= seg_display_d;
      seg_position_q <= seg_position_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.seg_display  = seg_display_q;
  assign bus.seg_position = seg_position_q;
  assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver
module tb_seg_scan_driver;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct {
    logic [7:0] pos;
    logic [6:0] disp;
    logic       fd;
  } slot_t;

  logic clk;
  logic rst;
  seg_scan_driver_if bus();

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  slot_t sb[$];
  int    push_idx   = 0;
  int    push_frame = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected contents of the next slot, computed from the inputs present at its load edge.
  function automatic void push_slot();
    slot_t      e;
    logic [3:0] nib;
    logic       phase;
    phase  = ((push_frame / BLINK_FRAMES) % 2) == 1;
    nib    = bus.digit_data[push_idx*4 +: 4];
    e.pos  = 8'hFF;
    e.pos[push_idx] = 1'b0;
    if (!bus.digit_en[push_idx] || (bus.blink_mask[push_idx] && phase))
      e.disp = 7'h00;
    else
      e.disp = SEG_TBL[nib];
    e.fd   = (push_idx == 7);
    sb.push_back(e);
    if (push_idx == 7) push_frame++;
    push_idx = (push_idx + 1) % 8;
  endfunction

  // Moves the bench model and the DUT forward together, without comparing.
  task automatic advance_to(input int idx);
    slot_t e;
    while (push_idx != idx) begin
      push_slot();
      e = sb.pop_front();
      repeat (SCAN_DIV) tick();
    end
  endtask

  task automatic test_reset();
    slot_t e;
    rst = 1'b0;
    bus.digit_data = 32'h7654_3210;
    bus.digit_en   = 8'hFF;
    bus.blink_mask = 8'h00;
    repeat (5) tick();
    checks++;
    if (bus.seg_position !== 8'hFF || bus.seg_display !== 7'h00 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold pos=%h disp=%h fd=%b required pos=FF disp=00 fd=0",
               bus.seg_position, bus.seg_display, bus.frame_done);
    end
    rst = 1'b1;
    for (int i = 0; i < SCAN_DIV - 1; i++) begin
      tick();
      checks++;
      if (bus.seg_position !== 8'hFF || bus.seg_display !== 7'h00) begin
        errors++;
        $display("FAIL first_load_wait edge=%0d pos=%h disp=%h required pos=FF disp=00",
                 i + 1, bus.seg_position, bus.seg_display);
      end
    end
    push_slot();
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.seg_position !== e.pos || bus.seg_display !== e.disp) begin
      errors++;
      $display("FAIL first_load pos=%h disp=%h required pos=%h disp=%h",
               bus.seg_position, bus.seg_display, e.pos, e.disp);
    end
    for (int c = 1; c < SCAN_DIV; c++) begin
      tick();
      checks++;
      if (bus.seg_position !== e.pos || bus.seg_display !== e.disp || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL first_hold c=%0d pos=%h disp=%h fd=%b required pos=%h disp=%h fd=0",
                 c, bus.seg_position, bus.seg_display, bus.frame_done, e.pos, e.disp);
      end
    end
    tick();
  endtask

  task automatic test_full_scan();
    slot_t e;
    repeat (9) push_slot();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c > 0) tick();
        checks++;
        if (bus.seg_position !== e.pos || bus.seg_display !== e.disp ||
            bus.frame_done !== (e.fd && c == 0)) begin
          errors++;
          $display("FAIL full_scan c=%0d pos=%h disp=%h fd=%b required pos=%h disp=%h fd=%b",
                   c, bus.seg_position, bus.seg_display, bus.frame_done,
                   e.pos, e.disp, e.fd && c == 0);
        end
      end
      tick();
    end
  endtask

  task automatic test_blanking();
    slot_t e;
    push_slot();
    bus.digit_en   = 8'b1111_1011;
    bus.digit_data = 32'h7654_3310;
    repeat (8) push_slot();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c > 0) tick();
        checks++;
        if (bus.seg_position !== e.pos || bus.seg_display !== e.disp ||
            bus.frame_done !== (e.fd && c == 0)) begin
          errors++;
          $display("FAIL blanking c=%0d pos=%h disp=%h fd=%b required pos=%h disp=%h fd=%b",
                   c, bus.seg_position, bus.seg_display, bus.frame_done,
                   e.pos, e.disp, e.fd && c == 0);
        end
      end
      tick();
    end
    bus.digit_en   = 8'hFF;
    bus.digit_data = 32'h7654_3210;
  endtask

  task automatic test_blink();
    slot_t e;
    int    lit = 0;
    int    dark = 0;
    push_slot();
    bus.blink_mask = 8'h01;
    bus.digit_data = 32'h7654_3218;
    repeat (40) push_slot();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.pos == 8'hFE && e.disp == 7'h7F) lit++;
      if (e.pos == 8'hFE && e.disp == 7'h00) dark++;
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c > 0) tick();
        checks++;
        if (bus.seg_position !== e.pos || bus.seg_display !== e.disp ||
            bus.frame_done !== (e.fd && c == 0)) begin
          errors++;
          $display("FAIL blink c=%0d pos=%h disp=%h fd=%b required pos=%h disp=%h fd=%b",
                   c, bus.seg_position, bus.seg_display, bus.frame_done,
                   e.pos, e.disp, e.fd && c == 0);
        end
      end
      tick();
    end
    checks++;
    if (lit < 2 || dark < 2) begin
      errors++;
      $display("FAIL blink_coverage lit=%0d dark=%0d required both >=2", lit, dark);
    end
    // Disabled and blinking together: dark in both phases.
    push_slot();
    bus.digit_en = 8'hFE;
    repeat (16) push_slot();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c > 0) tick();
        checks++;
        if (bus.seg_position !== e.pos || bus.seg_display !== e.disp ||
            bus.frame_done !== (e.fd && c == 0)) begin
          errors++;
          $display("FAIL enable_priority c=%0d pos=%h disp=%h fd=%b required pos=%h disp=%h fd=%b",
                   c, bus.seg_position, bus.seg_display, bus.frame_done,
                   e.pos, e.disp, e.fd && c == 0);
        end
      end
      tick();
    end
    bus.digit_en   = 8'hFF;
    bus.blink_mask = 8'h00;
    bus.digit_data = 32'h7654_3210;
  endtask

  task automatic test_mid_frame_change();
    slot_t e;
    advance_to(3);
    push_slot();
    bus.digit_data[23:20] = 4'hA;
    push_slot();
    push_slot();
    while (sb.size() > 1) begin
      e = sb.pop_front();
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c > 0) tick();
        checks++;
        if (bus.seg_position !== e.pos || bus.seg_display !== e.disp) begin
          errors++;
          $display("FAIL mid_change c=%0d pos=%h disp=%h required pos=%h disp=%h",
                   c, bus.seg_position, bus.seg_display, e.pos, e.disp);
        end
      end
      tick();
    end
    // Now inside digit 5's slot: rewriting its nibble must not disturb the held segments.
    e = sb.pop_front();
    for (int c = 0; c < SCAN_DIV; c++) begin
      if (c > 0) tick();
      checks++;
      if (bus.seg_position !== 8'hDF || bus.seg_display !== 7'h77) begin
        errors++;
        $display("FAIL own_slot_change c=%0d pos=%h disp=%h required pos=DF disp=77",
                 c, bus.seg_position, bus.seg_display);
      end
      if (c == 0) bus.digit_data[23:20] = 4'h5;
    end
    tick();
    repeat (8) push_slot();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c > 0) tick();
        checks++;
        if (bus.seg_position !== e.pos || bus.seg_display !== e.disp) begin
          errors++;
          $display("FAIL next_load c=%0d pos=%h disp=%h required pos=%h disp=%h",
                   c, bus.seg_position, bus.seg_display, e.pos, e.disp);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    slot_t e;
    advance_to(4);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.seg_position !== 8'hFF || bus.seg_display !== 7'h00 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pos=%h disp=%h fd=%b required pos=FF disp=00 fd=0",
               bus.seg_position, bus.seg_display, bus.frame_done);
    end
    sb.delete();
    push_idx   = 0;
    push_frame = 0;
    bus.blink_mask = 8'h01;
    bus.digit_data = 32'h7654_3218;
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < SCAN_DIV - 1; i++) begin
      tick();
      checks++;
      if (bus.seg_position !== 8'hFF || bus.seg_display !== 7'h00) begin
        errors++;
        $display("FAIL restart_wait edge=%0d pos=%h disp=%h required pos=FF disp=00",
                 i + 1, bus.seg_position, bus.seg_display);
      end
    end
    repeat (8) push_slot();
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c > 0) tick();
        checks++;
        if (bus.seg_position !== e.pos || bus.seg_display !== e.disp ||
            bus.frame_done !== (e.fd && c == 0)) begin
          errors++;
          $display("FAIL restart c=%0d pos=%h disp=%h fd=%b required pos=%h disp=%h fd=%b",
                   c, bus.seg_position, bus.seg_display, bus.frame_done,
                   e.pos, e.disp, e.fd && c == 0);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_blanking();
    test_blink();
    test_mid_frame_change();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
